sync_fifo_flags: RTL

Parametrised synchronous FIFO, next generation of the team's single-clock FIFO. Adds true simultaneous read/write, full-depth utilisation, an occupancy count, threshold flags, a read-data valid strobe, and sticky overflow/underflow error flags. It sits between a producer and a consumer in one clock domain and is the FIFO the UVM environment targets going forward.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_ram.sv | 20 ++
 rtl/sync_fifo_flags.sv | 69 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, width derivation and parameter legality checks for the FIFO family
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit params_ok(input int depth, input int afull, input int aempty);
    return depth >= 2 && (depth & (depth - 1)) == 0 && afull >= 1 && afull <= depth &&
           aempty >= 0 && aempty <= depth - 1;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage (clk, rst, we/waddr/wdata write port, re/raddr -> registered rdata)
module fifo_ram import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [ptr_w(FIFO_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         re,
  input  logic [ptr_w(FIFO_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO (wen/din in, ren -> dout/dout_valid) with count, empty/full, almost flags and sticky overflow/underflow
module sync_fifo_flags import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic                         ren,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  output logic [cnt_w(FIFO_DEPTH)-1:0] count,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int PTR_W = ptr_w(FIFO_DEPTH);
  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  if (!params_ok(FIFO_DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $fatal(1, "sync_fifo_flags: illegal FIFO_DEPTH/AFULL_TH/AEMPTY_TH");
  end
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             rd_acc, wr_acc;
  assign rd_acc = ren & ~empty;
  assign wr_acc = wen & (~full | rd_acc);
  assign count_next = (wr_acc & ~rd_acc) ? count + CNT_W'(1) :
                      (rd_acc & ~wr_acc) ? count - CNT_W'(1) : count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      dout_valid   <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      count        <= count_next;
      empty        <= count_next == '0;
      full         <= count_next == CNT_W'(FIFO_DEPTH);
      almost_empty <= count_next <= CNT_W'(AEMPTY_TH);
      almost_full  <= count_next >= CNT_W'(AFULL_TH);
      dout_valid   <= rd_acc;
      overflow     <= overflow | (wen & ~wr_acc);
      underflow    <= underflow | (ren & empty);
    end
  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(din),
    .re   (rd_acc),
    .raddr(rd_ptr),
    .rdata(dout)
  );
endmodule
